// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Owns every latch load enable, bubble flush and interrupt drain.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       id_ra,
  input  logic [1:0]       id_rb,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic [1:0]       ex_rd,
  input  logic             ex_RW,
  input  logic             ex_MR,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             int_req,
  input  logic             cnt_clr,
  output logic             pc_ld,
  output logic             if_id_ld,
  output logic             id_ex_ld,
  output logic             ex_m_ld,
  output logic             m_wb_ld,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             int_ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DLOAD =
    DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        cur;
  logic [DW-1:0] dcnt;
  logic          hz;
  logic          hz_eff;

  assign hz = ex_MR & ex_RW &
    ((id_use_ra & (id_ra == ex_rd)) |
     (id_use_rb & (id_rb == ex_rd)));

  // a taken branch overrides the load-use stall
  assign hz_eff = hz & ~br_taken;
  assign state  = cur;

  always_comb begin
    pc_ld       = 1'b1;
    if_id_ld    = 1'b1;
    id_ex_ld    = 1'b1;
    ex_m_ld     = 1'b1;
    m_wb_ld     = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    int_ack     = 1'b0;
    if (!reset || mem_busy) begin
      pc_ld    = 1'b0;
      if_id_ld = 1'b0;
      id_ex_ld = 1'b0;
      ex_m_ld  = 1'b0;
      m_wb_ld  = 1'b0;
    end else begin
      unique case (cur)
        RUN: begin
          if (int_req) begin
            pc_ld = 1'b1;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz) begin
            pc_ld       = 1'b0;
            if_id_ld    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        DRAIN: begin
          pc_ld       = 1'b0;
          if_id_flush = 1'b1;
          if (br_taken) begin
            pc_ld       = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz) begin
            if_id_ld    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        ACK: begin
          int_ack     = 1'b1;
          if_id_flush = 1'b1;
        end
        default: begin
          pc_ld    = 1'b0;
          if_id_ld = 1'b0;
          id_ex_ld = 1'b0;
          ex_m_ld  = 1'b0;
          m_wb_ld  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur         <= RUN;
      dcnt        <= '0;
      stall_count <= '0;
    end else begin
      if (cnt_clr)
        stall_count <= '0;
      else if (!pc_ld && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (!mem_busy) begin
        unique case (cur)
          RUN: begin
            if (int_req) begin
              cur  <= DRAIN;
              dcnt <= DLOAD;
            end
          end
          DRAIN: begin
            if (!hz_eff) begin
              if (dcnt == '0)
                cur <= ACK;
              else
                dcnt <= dcnt - DW'(1);
            end
          end
          ACK:     cur <= RUN;
          default: cur <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int D = 3;
  localparam int CW = 2;
  localparam int SMAX = (1 << CW) - 1;
  localparam logic [7:0] DEF = 8'b11111_00_0;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] id_ra, id_rb, ex_rd;
  logic id_use_ra, id_use_rb, ex_RW, ex_MR;
  logic br_taken, mem_busy, int_req, cnt_clr;
  logic pc_ld, if_id_ld, id_ex_ld, ex_m_ld, m_wb_ld;
  logic if_id_flush, id_ex_flush, int_ack;
  logic [1:0] state;
  logic [CW-1:0] stall_count;
  logic [7:0] outs;

  int errors = 0;
  int checks = 0;

  int m_st = 0;
  int m_cnt = 0;
  int m_sc = 0;

  always #5 clk = ~clk;

  assign outs = {pc_ld, if_id_ld, id_ex_ld, ex_m_ld,
                 m_wb_ld, if_id_flush, id_ex_flush, int_ack};

  pipe_hazard_ctrl #(
    .DRAIN_CYCLES(D),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_MR(ex_MR),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .int_req(int_req), .cnt_clr(cnt_clr),
    .pc_ld(pc_ld), .if_id_ld(if_id_ld),
    .id_ex_ld(id_ex_ld), .ex_m_ld(ex_m_ld),
    .m_wb_ld(m_wb_ld), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .int_ack(int_ack),
    .state(state), .stall_count(stall_count)
  );

  function automatic bit m_hz();
    return ex_MR && ex_RW &&
      ((id_use_ra && id_ra == ex_rd) ||
       (id_use_rb && id_rb == ex_rd));
  endfunction

  // expected {5 x ld, if_id_flush, id_ex_flush, int_ack}
  function automatic logic [7:0] exp_out();
    if (!reset || mem_busy) return 8'h00;
    if (m_st == 0) begin
      if (int_req) return DEF;
      if (br_taken) return 8'b11111_11_0;
      if (m_hz()) return 8'b00111_01_0;
      return DEF;
    end
    if (m_st == 1) begin
      if (br_taken) return 8'b11111_11_0;
      if (m_hz()) return 8'b00111_01_0;
      return 8'b01111_10_0;
    end
    return 8'b11111_10_1;
  endfunction

  task automatic model_next();
    logic [7:0] e;
    e = exp_out();
    if (!reset) begin
      m_st = 0; m_cnt = 0; m_sc = 0;
      return;
    end
    if (cnt_clr) m_sc = 0;
    else if (!e[7]) m_sc = (m_sc < SMAX) ? m_sc + 1 : SMAX;
    if (mem_busy) return;
    if (m_st == 0) begin
      if (int_req) begin m_st = 1; m_cnt = D - 1; end
    end else if (m_st == 1) begin
      if (!(m_hz() && !br_taken)) begin
        if (m_cnt == 0) m_st = 2;
        else m_cnt = m_cnt - 1;
      end
    end else begin
      m_st = 0;
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b1;
    id_ra = 2'd0; id_rb = 2'd0; ex_rd = 2'd0;
    id_use_ra = 1'b0; id_use_rb = 1'b0;
    ex_RW = 1'b0; ex_MR = 1'b0;
    br_taken = 1'b0; mem_busy = 1'b0;
    int_req = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_hz();
    ex_MR = 1'b1; ex_RW = 1'b1; ex_rd = 2'd2;
    id_ra = 2'd2; id_use_ra = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    int_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs !== 8'h00) begin
        errors++;
        $display("FAIL reset_outs got=%b want=%b", outs, 8'h00);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (state !== 2'd0 || stall_count !== '0) begin
      errors++;
      $display("FAIL reset_regs got state=%0d cnt=%0d want 0/0",
               state, stall_count);
    end
    checks++;
    if (outs !== DEF) begin
      errors++;
      $display("FAIL reset_release got=%b want=%b", outs, DEF);
    end
  endtask

  task automatic test_load_use();
    idle();
    set_hz();
    #1;
    checks++;
    if (outs !== 8'b00111_01_0) begin
      errors++;
      $display("FAIL lu_stall got=%b want=%b", outs, 8'b00111_01_0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_count !== 2'd1 || outs !== DEF) begin
      errors++;
      $display("FAIL lu_after got cnt=%0d outs=%b want 1/%b",
               stall_count, outs, DEF);
    end
    set_hz();
    id_use_ra = 1'b0;
    #1;
    checks++;
    if (outs !== DEF) begin
      errors++;
      $display("FAIL lu_unused got=%b want=%b", outs, DEF);
    end
    tick();
    checks++;
    if (stall_count !== 2'd1) begin
      errors++;
      $display("FAIL lu_unused_cnt got=%0d want=1", stall_count);
    end
  endtask

  task automatic test_branch();
    idle();
    set_hz();
    br_taken = 1'b1;
    #1;
    checks++;
    if (outs !== 8'b11111_11_0) begin
      errors++;
      $display("FAIL br_hz got=%b want=%b", outs, 8'b11111_11_0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_count !== 2'd1) begin
      errors++;
      $display("FAIL br_cnt got=%0d want=1", stall_count);
    end
  endtask

  task automatic test_interrupt();
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    int_req = 1'b1;
    #1;
    checks++;
    if (outs !== DEF) begin
      errors++;
      $display("FAIL int_req_cycle got=%b want=%b", outs, DEF);
    end
    tick();
    int_req = 1'b0;
    for (int i = 0; i < D; i++) begin
      #1;
      checks++;
      if (state !== 2'd1 || outs !== 8'b01111_10_0) begin
        errors++;
        $display("FAIL int_drain%0d got st=%0d outs=%b want 1/%b",
                 i, state, outs, 8'b01111_10_0);
      end
      tick();
    end
    #1;
    checks++;
    if (state !== 2'd2 || outs !== 8'b11111_10_1) begin
      errors++;
      $display("FAIL int_ack got st=%0d outs=%b want 2/%b",
               state, outs, 8'b11111_10_1);
    end
    tick();
    checks++;
    if (state !== 2'd0 || outs !== DEF || stall_count !== 2'd3) begin
      errors++;
      $display("FAIL int_done got st=%0d outs=%b cnt=%0d want 0/%b/3",
               state, outs, stall_count, DEF);
    end
  endtask

  task automatic test_drain_busy();
    int ack_at;
    ack_at = 0;
    idle();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      mem_busy = (k >= 2 && k <= 5);
      #1;
      if (mem_busy) begin
        checks++;
        if (outs !== 8'h00 || state !== 2'd1) begin
          errors++;
          $display("FAIL busy_freeze k=%0d got st=%0d outs=%b want 1/0",
                   k, state, outs);
        end
      end
      if (int_ack === 1'b1) ack_at = k;
      tick();
    end
    idle();
    checks++;
    if (ack_at != D + 1 + 4) begin
      errors++;
      $display("FAIL busy_latency got=%0d want=%0d", ack_at, D + 5);
    end
  endtask

  task automatic test_saturate();
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    set_hz();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (stall_count !== CW'((i < SMAX) ? i : SMAX)) begin
        errors++;
        $display("FAIL sat%0d got=%0d want=%0d",
                 i, stall_count, (i < SMAX) ? i : SMAX);
      end
    end
    cnt_clr = 1'b1;
    tick();
    checks++;
    if (stall_count !== '0) begin
      errors++;
      $display("FAIL clr_beats_inc got=%0d want=0", stall_count);
    end
    idle();
  endtask

  task automatic test_reset_mid_drain();
    idle();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (int_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain_ack got=%b want=0", int_ack);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || int_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain got st=%0d ack=%b want 0/0",
               state, int_ack);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      id_ra = 2'($urandom);
      id_rb = 2'($urandom);
      ex_rd = 2'($urandom);
      id_use_ra = 1'($urandom);
      id_use_rb = 1'($urandom);
      ex_RW = 1'($urandom);
      ex_MR = 1'($urandom);
      br_taken = ($urandom_range(0, 4) == 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      int_req = ($urandom_range(0, 5) == 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      #1;
      e = exp_out();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL rnd_outs n=%0d got=%b want=%b", n, outs, e);
      end
      tick();
      checks++;
      if (state !== 2'(m_st) || stall_count !== CW'(m_sc)) begin
        errors++;
        $display("FAIL rnd_regs n=%0d got st=%0d cnt=%0d want %0d/%0d",
                 n, state, stall_count, m_st, m_sc);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_interrupt();
    test_drain_busy();
    test_saturate();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
